seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, meaning consecutive identical input cycles required before a digit is accepted; legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port seg  input  7  active-low segment lines, bit0=a .. bit6=g.
REQ-005 The block SHALL have port an  input  4  active-low digit enables, bit0 = least significant digit.
REQ-006 The block SHALL have port dp  input  1  active-low decimal point; required high (off).
REQ-007 The block SHALL have port data_out  output  12  last complete recovered frame, {digit2,digit1,digit0}.
REQ-008 The block SHALL have port data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-009 The block SHALL have port pattern_err  output  1  one-cycle pulse when an accepted window is illegal.

Function
REQ-010 The block SHALL treat {an,seg,dp} as one sample; a stability counter (16 bit) SHALL clear to 0 whenever the sample differs from the previous cycle's sample and increment otherwise, saturating at STABLE_CYCLES-1.
REQ-011 FSM states SHALL be IDLE (an=4'b1111 or counter below threshold with no window), SETTLE (non-idle sample, counting), HELD (window already accepted, waiting for sample change).
REQ-012 Transitions: IDLE->SETTLE on non-idle an; SETTLE->HELD on the edge at which the sample has been identical for STABLE_CYCLES consecutive edges (acceptance); HELD or SETTLE->IDLE on an=4'b1111; HELD->SETTLE on any sample change to non-idle an; SETTLE restarts its count on change.
REQ-013 Exactly one acceptance SHALL occur per stable window; no re-acceptance while in HELD.
REQ-014 On acceptance with an in {4'b1110, 4'b1101, 4'b1011}, dp=1, and seg matching one of the 16 hex patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110), the decoded nibble SHALL be stored in the digit slot selected by an and that slot's captured flag set.
REQ-015 Re-acceptance of an already-captured slot within a frame SHALL overwrite that nibble (latest wins).
REQ-016 When all three captured flags become set, on the next edge data_out SHALL load the three nibbles, data_valid SHALL pulse for one cycle, and all flags SHALL clear.
REQ-017 On acceptance with unknown seg pattern, dp=0, or an not in the three legal codes and not 4'b1111 (e.g. 4'b0111, multi-hot), pattern_err SHALL pulse on the next edge, all captured flags SHALL clear, and data_out SHALL hold.
REQ-018 data_valid and pattern_err SHALL never assert in the same cycle; an error acceptance coinciding with frame completion is impossible since one acceptance per cycle.
REQ-019 data_out SHALL change only with data_valid and SHALL hold indefinitely otherwise.
REQ-020 Inputs SHALL be assumed synchronous to clk; no synchronizer stages.

Reset
REQ-021 While clr=1 at a rising edge: data_out=12'h000, data_valid=0, pattern_err=0, counter=0, captured flags=0, FSM=IDLE.
REQ-022 clr asserted mid-window or mid-frame SHALL discard all partial captures; first acceptance after release requires a full STABLE_CYCLES window.

Verification
REQ-023 Scan 12'h3A7 (an 1110/seg 1111000, 1101/0001000, 1011/0110000), each window 40 cycles, STABLE_CYCLES=16 -> data_valid one pulse, data_out=12'h3A7.
REQ-024 Windows of 10 cycles with STABLE_CYCLES=16 -> no data_valid, no pattern_err, data_out stays 12'h000.
REQ-025 Digit0 seg=1111111 held 20 cycles -> pattern_err single pulse; subsequent valid 12'h105 frame -> data_valid, data_out=12'h105.
REQ-026 an=4'b1100 stable 20 cycles, then dp=0 window -> two pattern_err pulses, data_out unchanged.
REQ-027 Digit0=1, digit1=2, clr pulse one cycle, then digit2=3, digit0=4, digit1=5 -> single data_valid, data_out=12'h354.
REQ-028 Glitch: seg toggles for one cycle at cycle 12 of a 30-cycle window -> acceptance delayed to 16 cycles after glitch; exactly one acceptance per window.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 3-digit hex value from a multiplexed,
//   active-low 7-segment display scan by sampling the display lines directly.
// Latency: a digit is accepted on the STABLE_CYCLES-th consecutive edge that
//   sees the same {an,seg,dp}; frame output follows one edge after the third
//   digit is captured; pattern errors pulse one edge after acceptance.
// Backpressure: none; the scan source is free-running and is never stalled.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   seg[6:0]     active-low segments, bit0=a .. bit6=g
//   an[3:0]      active-low digit enables, bit0 = least significant digit
//   dp           active-low decimal point, must be high (off) for a legal digit
//   data_out     last complete frame {digit2,digit1,digit0}
//   data_valid   one-cycle pulse when data_out is updated
//   pattern_err  one-cycle pulse when an accepted window is illegal

module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        pattern_err
);

  // Counter saturates at STABLE_CYCLES-1. A window is accepted on the edge
  // where the counter moves from STABLE_CYCLES-2 to STABLE_CYCLES-1, i.e. the
  // edge at which the sample has been seen on STABLE_CYCLES consecutive edges.
  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] CNT_ACC = 16'(STABLE_CYCLES - 2);

  // Blank display sample: no digit enabled, all segments and dp off.
  localparam logic [11:0] IDLE_SAMPLE = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  // Returns {hit, nibble}; hit=0 for any segment pattern outside the hex set.
  function automatic logic [4:0] hex_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h10;
      7'b1111001: return 5'h11;
      7'b0100100: return 5'h12;
      7'b0110000: return 5'h13;
      7'b0011001: return 5'h14;
      7'b0010010: return 5'h15;
      7'b0000010: return 5'h16;
      7'b1111000: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0010000: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b0000011: return 5'h1B;
      7'b1000110: return 5'h1C;
      7'b0100001: return 5'h1D;
      7'b0000110: return 5'h1E;
      7'b0001110: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Registered state
  state_t            state_q;
  logic [11:0]       prev_q;
  logic [15:0]       cnt_q;
  logic [2:0]        cap_q;
  logic [2:0][3:0]   dig_q;
  logic [11:0]       data_out_q;
  logic              data_valid_q;
  logic              pattern_err_q;

  // Next-state and decode
  logic [11:0]       sample_w;
  logic              same_w;
  logic              idle_w;
  logic              accept_w;
  logic              hit_w;
  logic [3:0]        nib_w;
  logic              slot_ok_w;
  logic [1:0]        slot_w;
  logic              legal_w;
  logic              complete_w;
  logic [15:0]       cnt_d;
  logic [2:0]        cap_d;
  logic [2:0][3:0]   dig_d;

  assign sample_w = {an, seg, dp};

  // Stability tracking and acceptance detection
  always_comb begin
    same_w = (sample_w == prev_q);
    idle_w = (an == 4'b1111);

    if (!same_w) begin
      cnt_d = 16'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    // HELD blocks re-acceptance of a window that has already been taken.
    accept_w = !idle_w && same_w && (state_q != S_HELD) && (cnt_q == CNT_ACC);
  end

  // Classification of the sample being accepted
  always_comb begin
    {hit_w, nib_w} = hex_decode(seg);

    slot_ok_w = 1'b1;
    slot_w    = 2'd0;
    case (an)
      4'b1110: slot_w = 2'd0;
      4'b1101: slot_w = 2'd1;
      4'b1011: slot_w = 2'd2;
      default: slot_ok_w = 1'b0;
    endcase

    legal_w = slot_ok_w && dp && hit_w;
  end

  // Digit capture. Frames complete one edge after the last flag sets; a
  // second acceptance cannot land on that edge because the count must rerun.
  always_comb begin
    complete_w = (cap_q == 3'b111);
    cap_d      = cap_q;
    dig_d      = dig_q;

    if (complete_w) begin
      cap_d = 3'b000;
    end

    if (accept_w) begin
      if (legal_w) begin
        dig_d[slot_w] = nib_w;
        cap_d[slot_w] = 1'b1;
      end else begin
        cap_d = 3'b000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_IDLE;
      prev_q        <= IDLE_SAMPLE;
      cnt_q         <= 16'd0;
      cap_q         <= 3'b000;
      dig_q         <= '0;
      data_out_q    <= 12'h000;
      data_valid_q  <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      prev_q <= sample_w;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      dig_q  <= dig_d;

      case (state_q)
        S_IDLE: begin
          if (!idle_w) begin
            state_q <= accept_w ? S_HELD : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (idle_w) begin
            state_q <= S_IDLE;
          end else if (accept_w) begin
            state_q <= S_HELD;
          end
        end
        S_HELD: begin
          if (idle_w) begin
            state_q <= S_IDLE;
          end else if (!same_w) begin
            state_q <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      data_valid_q  <= complete_w;
      pattern_err_q <= accept_w && !legal_w;
      if (complete_w) begin
        data_out_q <= dig_q;
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign pattern_err = pattern_err_q;

  a_valid_err_excl : assert property (@(posedge clk) disable iff (clr)
    !(data_valid && pattern_err));

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic        dp  = 1'b1;
  logic [11:0] data_out;
  logic        data_valid;
  logic        pattern_err;

  seg_scan_decoder #(.STABLE_CYCLES(N)) dut (
    .clk         (clk),
    .clr         (clr),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Segment images of hex digits 0..F, indexed by value.
  logic [6:0] hex_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state
  logic [11:0] m_prev   = 12'hFFF;
  int          m_run    = 0;
  logic [3:0]  m_dig [3];
  logic [2:0]  m_cap    = 3'b000;
  logic [11:0] exp_data = 12'h000;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;
  bit          model_live = 1'b0;

  int cyc = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = -1;
  int t_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: run length of the current sample, hex lookup by table.
  task automatic model_step();
    logic [11:0] cur;
    logic [3:0]  pat;
    int slot;
    int nib;
    model_live = 1'b1;
    if (clr) begin
      m_prev    = 12'hFFF;
      m_run     = 0;
      m_cap     = 3'b000;
      for (int i = 0; i < 3; i++) m_dig[i] = 4'h0;
      exp_data  = 12'h000;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      cur = {an, seg, dp};
      if (cur != m_prev) m_run = 1;
      else if (m_run < 1000000) m_run++;
      m_prev = cur;

      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (m_cap == 3'b111) begin
        exp_valid = 1'b1;
        exp_data  = {m_dig[2], m_dig[1], m_dig[0]};
        m_cap     = 3'b000;
      end

      if (an != 4'hF && m_run == N) begin
        slot = -1;
        for (int i = 0; i < 3; i++) begin
          pat = 4'hF;
          pat[i] = 1'b0;
          if (an == pat) slot = i;
        end
        nib = -1;
        for (int k = 0; k < 16; k++) if (seg == hex_seg[k]) nib = k;
        if (slot >= 0 && nib >= 0 && dp) begin
          m_dig[slot] = nib[3:0];
          m_cap[slot] = 1'b1;
        end else begin
          exp_err = 1'b1;
          m_cap   = 3'b000;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("data_out", 32'(data_out), 32'(exp_data));
      check("data_valid", 32'(data_valid), 32'(exp_valid));
      check("pattern_err", 32'(pattern_err), 32'(exp_err));
      if (data_valid === 1'b1) begin
        dv_cnt++;
        last_valid_cyc = cyc;
      end
      if (pattern_err === 1'b1) err_cnt++;
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an  = a;
    seg = s;
    dp  = d;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic clear_counts();
    dv_cnt = 0;
    err_cnt = 0;
    last_valid_cyc = -1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset data_out", 32'(data_out), 32'h000);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset pattern_err", 32'(pattern_err), 32'h0);
    clr = 1'b0;
    idle(3);

    // Short windows never reach acceptance.
    clear_counts();
    hold(4'b1110, 7'b1111001, 1'b1, 10);
    hold(4'b1101, 7'b0100100, 1'b1, 10);
    hold(4'b1011, 7'b0110000, 1'b1, 10);
    idle(5);
    check("short dv count", 32'(dv_cnt), 32'd0);
    check("short err count", 32'(err_cnt), 32'd0);
    check("short data_out", 32'(data_out), 32'h000);

    // Frame 3A7 with 40-cycle windows.
    clear_counts();
    hold(4'b1110, 7'b1111000, 1'b1, 40);
    hold(4'b1101, 7'b0001000, 1'b1, 40);
    t_start = cyc;
    hold(4'b1011, 7'b0110000, 1'b1, 40);
    idle(5);
    check("3A7 dv count", 32'(dv_cnt), 32'd1);
    check("3A7 err count", 32'(err_cnt), 32'd0);
    check("3A7 data_out", 32'(data_out), 32'h3A7);
    check("3A7 model data", 32'(exp_data), 32'h3A7);
    check("3A7 valid latency", 32'(last_valid_cyc - t_start), 32'd17);

    // Unknown pattern, then a good frame 105.
    clear_counts();
    hold(4'b1110, 7'b1111111, 1'b1, 20);
    hold(4'b1110, 7'b0010010, 1'b1, 20);
    hold(4'b1101, 7'b1000000, 1'b1, 20);
    hold(4'b1011, 7'b1111001, 1'b1, 20);
    idle(5);
    check("105 err count", 32'(err_cnt), 32'd1);
    check("105 dv count", 32'(dv_cnt), 32'd1);
    check("105 data_out", 32'(data_out), 32'h105);

    // Multi-hot enable, then decimal point lit.
    clear_counts();
    hold(4'b1100, 7'b0000000, 1'b1, 20);
    hold(4'b1110, 7'b1000000, 1'b0, 20);
    idle(5);
    check("bad-an/dp err count", 32'(err_cnt), 32'd2);
    check("bad-an/dp dv count", 32'(dv_cnt), 32'd0);
    check("bad-an/dp data_out", 32'(data_out), 32'h105);

    // Reset mid-frame discards digits 1 and 2.
    clear_counts();
    hold(4'b1110, 7'b1111001, 1'b1, 20);
    hold(4'b1101, 7'b0100100, 1'b1, 20);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr data_out", 32'(data_out), 32'h000);
    clear_counts();
    hold(4'b1011, 7'b0110000, 1'b1, 20);
    hold(4'b1110, 7'b0011001, 1'b1, 20);
    hold(4'b1101, 7'b0010010, 1'b1, 20);
    idle(5);
    check("354 dv count", 32'(dv_cnt), 32'd1);
    check("354 err count", 32'(err_cnt), 32'd0);
    check("354 data_out", 32'(data_out), 32'h354);

    // Glitch at cycle 12 of the last window restarts its count.
    clear_counts();
    hold(4'b1110, 7'b0010000, 1'b1, 30);
    hold(4'b1101, 7'b0000110, 1'b1, 30);
    hold(4'b1011, 7'b1000110, 1'b1, 12);
    hold(4'b1011, 7'b1000111, 1'b1, 1);
    t_start = cyc;
    hold(4'b1011, 7'b1000110, 1'b1, 17);
    idle(5);
    check("glitch dv count", 32'(dv_cnt), 32'd1);
    check("glitch err count", 32'(err_cnt), 32'd0);
    check("glitch data_out", 32'(data_out), 32'hCE9);
    check("glitch model data", 32'(exp_data), 32'hCE9);
    check("glitch valid latency", 32'(last_valid_cyc - t_start), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
